decode_seq: RTL and testbench
=============================

Name: decode_seq

Overview:
- Registered, handshaked successor to the combinational Thumb decoder; sits between the fetch buffer and the execute stage.
- Decodes one 16-bit instruction per accepted beat into opcode plus immediate, behind a valid/ready interface.
- Expands PUSH/POP register lists into one micro-op per register, so execute handles a single register transfer per cycle.

Parameters:
- INSTR_W, 16, instruction width; bits [15:10] are the decode field.
- OPC_W, 5, opcode width.
- IMM_W, 8, immediate width; must be at least 5.
- EXPAND_EN, 1, 1 = expand PUSH/POP lists; 0 = emit PUSH/POP as one op carrying the raw list.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- flush  in  1  synchronous; drops the held output and aborts any expansion
- in_valid  in  1  instruction valid
- in_instr  in  INSTR_W  instruction
- in_ready  out  1  block accepts in_instr this cycle
- out_valid  out  1  micro-op valid
- out_ready  in  1  consumer accepts micro-op
- out_opcode  out  OPC_W  decoded opcode
- out_imm  out  IMM_W  immediate or register index
- out_last  out  1  final micro-op of the current instruction

Behaviour:
- Opcode constants: NULL=0x00, ADDSP=0x01, SUBSP=0x02, MOVS=0x03, MOV=0x04, ADDS=0x05, LDRPC=0x06, LDR=0x07, STR=0x08, BN=0x09, POP=0x0A, PUSH=0x0B, CMP=0x10, BLEN=0x18.
- Decode on instr[15:10], first match wins:
  - 10101? ADDSP; 101100 SUBSP; 00100? MOVS.
  - 010001 MOV, imm = {0, instr[7], instr[2:0]}.
  - 000111 ADDS; 01001? LDRPC; 01101? LDR; 01100? STR; 11100? BN.
  - 00101? CMP, imm = instr[10:8].
  - 10110? PUSH; 10111? POP.
  - 110111 BLEN, imm = instr[7:0].
  - Anything else is NULL.
  - Where no immediate is listed, imm = 0. All imm values are zero-extended to IMM_W.
- Reset values: out_valid=0, out_opcode=NULL, out_imm=0, out_last=0, sequencer IDLE, pending mask=0.
- Latency: an instruction accepted in cycle N produces out_valid in cycle N+1.
- Output register handshake:
  - A micro-op is held stable while out_valid=1 and out_ready=0.
  - It is released on out_valid and out_ready both high.
- in_ready = (state==IDLE) and (!out_valid or out_ready). This allows back-to-back single-op instructions at one per cycle.
- Non-expanding instructions: out_last=1.
- Sequencer states:
  - IDLE: on accept of PUSH/POP with EXPAND_EN=1, form mask = {instr[8], instr[7:0]} (9 bits; bit 8 = LR for PUSH, PC for POP).
    - If mask has exactly one bit set: emit that op with last=1, stay IDLE.
    - If mask is empty: emit one op with imm=0 and last=1, stay IDLE (degenerate case, no hang).
    - Otherwise: emit the first op, store the remaining mask, go to EXPAND.
  - EXPAND: on each output handshake, load the next op from the pending mask. Order is lowest set bit first.
  - Register index in imm[3:0]: bits 0-7 map to index 0-7; bit 8 maps to 14 (PUSH) or 15 (POP).
  - out_last=1 on the op that consumes the final set bit; the sequencer then returns to IDLE.
  - in_ready stays 0 throughout EXPAND.
- EXPAND_EN=0: PUSH/POP emitted as one op, imm = instr[7:0], last=1; the instr[8] bit is dropped.
- flush:
  - Next cycle: out_valid=0, state IDLE, mask=0.
  - flush takes priority over a simultaneous accept; in_ready is forced to 0 while flush=1.
- rst mid-expansion clears everything asynchronously; no partial op survives.
- in_valid with in_ready=0 is not consumed; the source must hold in_instr.

Decomposition:
- Shared package decode_pkg: opcode localparams, OPC_W/IMM_W defaults, LR/PC index constants (14/15), sequencer state encoding.
- Natural sub-module: decode_core, the combinational pattern-to-opcode/imm table. It is instantiated once; decode_seq adds the registers, handshake and expansion logic.

Test Plan:
- Reset then idle -> out_valid=0, out_opcode=0x00, in_ready=1.
- Back-to-back MOV 0x4687 then CMP 0x2A05, out_ready=1 -> cycle+1: opcode 0x04, imm 0x0F, last=1; cycle+2: opcode 0x10, imm 0x02, last=1; no bubble.
- PUSH 0xB5A1 (list 10100001, LR), out_ready=1 -> four ops: opcode 0x0B with imm 0, 5, 7, 14; last=1 only on 14; in_ready=0 for three cycles.
- POP 0xBC00 (empty list) -> one op: opcode 0x0A, imm 0, last=1; state back to IDLE.
- POP 0xBD03 with out_ready stalled 3 cycles on the second op -> imm 0, 1, 15 in order; stalled op held stable; no op lost or duplicated.
- flush asserted during expansion of PUSH 0xB4FF after two ops -> next cycle out_valid=0, in_ready=1; next instruction 0x1C48 decodes as ADDS (0x05).

Source files
------------

// File: rtl/decode_pkg.sv
// Shared definitions for the Thumb decode sequencer.
// Contents: opcode constants, default widths, LR/PC register indices,
// sequencer state encoding, and helpers for walking a PUSH/POP list.
package decode_pkg;

    localparam int INSTR_W_DEF = 16;
    localparam int OPC_W_DEF   = 5;
    localparam int IMM_W_DEF   = 8;
    localparam int LIST_W      = 9;   // r0..r7 plus LR/PC

    localparam logic [4:0] OPC_NULL  = 5'h00;
    localparam logic [4:0] OPC_ADDSP = 5'h01;
    localparam logic [4:0] OPC_SUBSP = 5'h02;
    localparam logic [4:0] OPC_MOVS  = 5'h03;
    localparam logic [4:0] OPC_MOV   = 5'h04;
    localparam logic [4:0] OPC_ADDS  = 5'h05;
    localparam logic [4:0] OPC_LDRPC = 5'h06;
    localparam logic [4:0] OPC_LDR   = 5'h07;
    localparam logic [4:0] OPC_STR   = 5'h08;
    localparam logic [4:0] OPC_BN    = 5'h09;
    localparam logic [4:0] OPC_POP   = 5'h0A;
    localparam logic [4:0] OPC_PUSH  = 5'h0B;
    localparam logic [4:0] OPC_CMP   = 5'h10;
    localparam logic [4:0] OPC_BLEN  = 5'h18;

    localparam logic [3:0] IDX_LR = 4'd14;
    localparam logic [3:0] IDX_PC = 4'd15;

    typedef enum logic {
        SEQ_IDLE,
        SEQ_EXPAND
    } seq_state_e;

    // Position of the lowest set bit; 0 for an empty mask.
    function automatic logic [3:0] lowest_set(input logic [LIST_W-1:0] m);
        logic [3:0] pos;
        pos = 4'd0;
        // Scanning downwards lets the lowest set bit be the final assignment.
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (m[i]) pos = 4'(i);
        end
        return pos;
    endfunction

    // List bit position to architectural register index.
    function automatic logic [3:0] list_reg_index(input logic [3:0] pos,
                                                  input logic       is_pop);
        logic [3:0] idx;
        if (pos == 4'd8) idx = is_pop ? IDX_PC : IDX_LR;
        else             idx = pos;
        return idx;
    endfunction

endpackage

// File: rtl/decode_core.sv
// Combinational Thumb decode table: maps instr[15:10] to an opcode and
// extracts the immediate / register field. First matching pattern wins.
// Ports:
//   instr_i    instruction word
//   opcode_o   decoded opcode
//   imm_o      immediate, zero-extended (or truncated) to IMM_W
//   is_list_o  instruction is a PUSH or POP carrying a register list
module decode_core
    import decode_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int OPC_W   = OPC_W_DEF,
    parameter int IMM_W   = IMM_W_DEF
) (
    input  logic [INSTR_W-1:0] instr_i,
    output logic [OPC_W-1:0]   opcode_o,
    output logic [IMM_W-1:0]   imm_o,
    output logic               is_list_o
);

    logic [5:0] field;
    logic [4:0] opc;
    logic [7:0] imm8;

    assign field = instr_i[15:10];

    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves a variable unassigned would infer a latch.
    always_comb begin
        opc  = OPC_NULL;
        imm8 = 8'h00;
        // if/else chain gives explicit priority where patterns overlap
        // (SUBSP 101100 shadows half of the PUSH pattern).
        if      (field ==? 6'b10101?) opc = OPC_ADDSP;
        else if (field ==? 6'b101100) opc = OPC_SUBSP;
        else if (field ==? 6'b00100?) opc = OPC_MOVS;
        else if (field ==? 6'b010001) begin
            opc  = OPC_MOV;
            imm8 = {4'b0000, instr_i[7], instr_i[2:0]};
        end
        else if (field ==? 6'b000111) opc = OPC_ADDS;
        else if (field ==? 6'b01001?) opc = OPC_LDRPC;
        else if (field ==? 6'b01101?) opc = OPC_LDR;
        else if (field ==? 6'b01100?) opc = OPC_STR;
        else if (field ==? 6'b11100?) opc = OPC_BN;
        else if (field ==? 6'b00101?) begin
            opc  = OPC_CMP;
            imm8 = {5'b00000, instr_i[10:8]};
        end
        else if (field ==? 6'b10110?) opc = OPC_PUSH;
        else if (field ==? 6'b10111?) opc = OPC_POP;
        else if (field ==? 6'b110111) begin
            opc  = OPC_BLEN;
            imm8 = instr_i[7:0];
        end
    end

    assign opcode_o  = OPC_W'(opc);
    assign imm_o     = IMM_W'(imm8);
    assign is_list_o = (opc == OPC_PUSH) || (opc == OPC_POP);

endmodule

// File: rtl/decode_seq.sv
// Registered, valid/ready Thumb decoder. Emits one micro-op per cycle and
// expands PUSH/POP register lists into one micro-op per register, lowest
// register first.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   flush                  drop held output and abort any expansion
//   in_valid/in_instr      instruction from fetch buffer
//   in_ready               instruction accepted this cycle
//   out_valid/out_ready    micro-op handshake to execute
//   out_opcode/out_imm     decoded opcode, immediate or register index
//   out_last               final micro-op of the current instruction
module decode_seq
    import decode_pkg::*;
#(
    parameter int INSTR_W   = INSTR_W_DEF,
    parameter int OPC_W     = OPC_W_DEF,
    parameter int IMM_W     = IMM_W_DEF,
    parameter bit EXPAND_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPC_W-1:0]   out_opcode,
    output logic [IMM_W-1:0]   out_imm,
    output logic               out_last
);

    seq_state_e        state_q, state_d;
    logic [LIST_W-1:0] mask_q, mask_d;       // registers still to emit
    logic              out_valid_q, out_valid_d;
    logic [OPC_W-1:0]  out_opcode_q, out_opcode_d;
    logic [IMM_W-1:0]  out_imm_q, out_imm_d;
    logic              out_last_q, out_last_d;

    logic [OPC_W-1:0]  dec_opcode;
    logic [IMM_W-1:0]  dec_imm;
    logic              dec_is_list;

    logic              accept;
    logic              out_hs;
    logic              held_is_pop;
    logic [LIST_W-1:0] in_mask, in_rest;
    logic [LIST_W-1:0] next_rest;
    logic [3:0]        in_first_pos, next_pos;

    decode_core #(
        .INSTR_W (INSTR_W),
        .OPC_W   (OPC_W),
        .IMM_W   (IMM_W)
    ) u_core (
        .instr_i   (in_instr),
        .opcode_o  (dec_opcode),
        .imm_o     (dec_imm),
        .is_list_o (dec_is_list)
    );

    // A new instruction is only taken once the held op is the last of its
    // instruction and is leaving (or nothing is held).
    assign in_ready = !flush && (state_q == SEQ_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready;

    // List of the incoming PUSH/POP: bit 8 is LR (PUSH) or PC (POP).
    assign in_mask      = in_instr[8:0];
    assign in_first_pos = lowest_set(in_mask);
    assign in_rest      = in_mask & (in_mask - LIST_W'(1));   // clear lowest bit

    assign held_is_pop  = (out_opcode_q == OPC_W'(OPC_POP));
    assign next_pos     = lowest_set(mask_q);
    assign next_rest    = mask_q & (mask_q - LIST_W'(1));

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        out_valid_d  = out_valid_q;
        out_opcode_d = out_opcode_q;
        out_imm_d    = out_imm_q;
        out_last_d   = out_last_q;

        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = SEQ_IDLE;
            mask_d      = '0;
        end else if (state_q == SEQ_EXPAND) begin
            // Opcode stays PUSH/POP; only the register index advances.
            if (out_hs) begin
                out_imm_d  = IMM_W'(list_reg_index(next_pos, held_is_pop));
                out_last_d = (next_rest == '0);
                mask_d     = next_rest;
                if (next_rest == '0) state_d = SEQ_IDLE;
            end
        end else if (accept) begin
            out_valid_d  = 1'b1;
            out_opcode_d = dec_opcode;
            if (dec_is_list && EXPAND_EN) begin
                // An empty list still emits one op (index 0) so the
                // instruction retires instead of vanishing.
                out_imm_d  = IMM_W'(list_reg_index(in_first_pos,
                                     dec_opcode == OPC_W'(OPC_POP)));
                out_last_d = (in_rest == '0);
                mask_d     = in_rest;
                if (in_rest != '0) state_d = SEQ_EXPAND;
            end else if (dec_is_list) begin
                out_imm_d  = IMM_W'(in_instr[7:0]);
                out_last_d = 1'b1;
            end else begin
                out_imm_d  = dec_imm;
                out_last_d = 1'b1;
            end
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SEQ_IDLE;
            mask_q       <= '0;
            out_valid_q  <= 1'b0;
            out_opcode_q <= OPC_W'(OPC_NULL);
            out_imm_q    <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            out_valid_q  <= out_valid_d;
            out_opcode_q <= out_opcode_d;
            out_imm_q    <= out_imm_d;
            out_last_q   <= out_last_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_opcode = out_opcode_q;
    assign out_imm    = out_imm_q;
    assign out_last   = out_last_q;

endmodule

// File: tb/tb_decode_seq.sv
// Self-checking bench for decode_seq: directed scenarios plus randomized
// traffic, compared against a queue-based micro-op reference model.
module tb_decode_seq;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_opcode;
    logic [7:0]  out_imm;
    logic        out_last;

    int n_tests;
    int n_fail;

    decode_seq #(
        .INSTR_W   (16),
        .OPC_W     (5),
        .IMM_W     (8),
        .EXPAND_EN (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opcode (out_opcode),
        .out_imm    (out_imm),
        .out_last   (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int K_NONE = 0, K_MOV = 1, K_CMP = 2, K_BLEN = 3, K_LIST = 4;

    typedef struct {
        logic [5:0] val;
        logic [5:0] care;
        logic [4:0] opc;
        int         kind;
    } pat_t;

    typedef struct {
        logic [4:0] opc;
        logic [7:0] imm;
        logic       last;
    } op_t;

    pat_t pats[13];
    op_t  sb[$];   // ops still owed by the DUT; sb[0] is the one on display

    initial begin
        pats[0]  = '{6'b101010, 6'b111110, 5'h01, K_NONE};
        pats[1]  = '{6'b101100, 6'b111111, 5'h02, K_NONE};
        pats[2]  = '{6'b001000, 6'b111110, 5'h03, K_NONE};
        pats[3]  = '{6'b010001, 6'b111111, 5'h04, K_MOV};
        pats[4]  = '{6'b000111, 6'b111111, 5'h05, K_NONE};
        pats[5]  = '{6'b010010, 6'b111110, 5'h06, K_NONE};
        pats[6]  = '{6'b011010, 6'b111110, 5'h07, K_NONE};
        pats[7]  = '{6'b011000, 6'b111110, 5'h08, K_NONE};
        pats[8]  = '{6'b111000, 6'b111110, 5'h09, K_NONE};
        pats[9]  = '{6'b001010, 6'b111110, 5'h10, K_CMP};
        pats[10] = '{6'b101100, 6'b111110, 5'h0B, K_LIST};
        pats[11] = '{6'b101110, 6'b111110, 5'h0A, K_LIST};
        pats[12] = '{6'b110111, 6'b111111, 5'h18, K_BLEN};
    end

    // Append every micro-op the instruction should produce.
    function automatic void model_accept(input logic [15:0] ins);
        logic [5:0] f;
        int         hit;
        op_t        op;
        logic [8:0] list;
        f   = ins[15:10];
        hit = -1;
        for (int i = 0; i < 13; i++) begin
            if (hit < 0 && ((f & pats[i].care) == (pats[i].val & pats[i].care))) hit = i;
        end
        if (hit < 0) begin
            op = '{5'h00, 8'h00, 1'b1};
            sb.push_back(op);
        end else if (pats[hit].kind == K_LIST) begin
            list = ins[8:0];
            if (list == 9'd0) begin
                op = '{pats[hit].opc, 8'h00, 1'b1};
                sb.push_back(op);
            end else begin
                for (int b = 0; b < 9; b++) begin
                    if (list[b]) begin
                        op.opc  = pats[hit].opc;
                        op.imm  = (b < 8) ? 8'(b) : ((pats[hit].opc == 5'h0A) ? 8'd15 : 8'd14);
                        op.last = 1'b0;
                        sb.push_back(op);
                    end
                end
                sb[sb.size() - 1].last = 1'b1;
            end
        end else begin
            op.opc  = pats[hit].opc;
            op.last = 1'b1;
            case (pats[hit].kind)
                K_MOV:   op.imm = {4'b0000, ins[7], ins[2:0]};
                K_CMP:   op.imm = {5'b00000, ins[10:8]};
                K_BLEN:  op.imm = ins[7:0];
                default: op.imm = 8'h00;
            endcase
            sb.push_back(op);
        end
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, then
    // advance the model by what the upcoming edge will do.
    task automatic step(input logic v, input logic [15:0] ins, input logic ordy,
                        input logic fl, output logic acc);
        logic exp_rdy;
        @(negedge clk);
        in_valid  = v;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        #1;
        // Ready only when nothing is owed beyond the op now leaving.
        exp_rdy = !fl && (sb.size() == 0 || (sb.size() == 1 && ordy));
        check("in_ready", in_ready, exp_rdy);
        check("out_valid", out_valid, sb.size() != 0);
        if (sb.size() != 0 && out_valid) begin
            check("out_opcode", out_opcode, sb[0].opc);
            check("out_imm", out_imm, sb[0].imm);
            check("out_last", out_last, sb[0].last);
        end
        acc = v && exp_rdy;
        if (sb.size() != 0 && ordy) void'(sb.pop_front());
        if (fl) sb.delete();
        if (acc) model_accept(ins);
    endtask

    task automatic send(input logic [15:0] ins);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) step(1'b1, ins, 1'b1, 1'b0, acc);
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 40 && sb.size() != 0; i++) step(1'b0, 16'h0000, 1'b1, 1'b0, acc);
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] r;
        logic [8:0]  l;
        logic [6:0]  hdr;
        hdr = ($urandom_range(0, 1) != 0) ? 7'b1011010 : 7'b1011110;
        case ($urandom_range(0, 3))
            0: r = 16'($urandom);
            1: begin l = 9'($urandom); r = {hdr, l}; end
            2: begin l = 9'd1 << $urandom_range(0, 8); r = {hdr, l}; end
            default: begin
                l = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom) & 9'($urandom);
                r = {hdr, l};
            end
        endcase
        return r;
    endfunction

    initial begin
        logic        acc;
        logic        holding;
        logic [15:0] cur;
        logic        ordy, fl;

        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 16'h0000;
        out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_opcode", out_opcode, 5'h00);
        check("rst_out_imm", out_imm, 8'h00);
        check("rst_out_last", out_last, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1);
        step(1'b0, 16'h0000, 1'b1, 1'b0, acc);

        // Back-to-back MOV then CMP, no bubble
        step(1'b1, 16'h4687, 1'b1, 1'b0, acc);
        check("mov_accept", acc, 1);
        step(1'b1, 16'h2A05, 1'b1, 1'b0, acc);
        check("cmp_accept", acc, 1);
        check("mov_opcode", out_opcode, 5'h04);
        check("mov_imm", out_imm, 8'h0F);
        step(1'b0, 16'h0000, 1'b1, 1'b0, acc);
        check("cmp_opcode", out_opcode, 5'h10);
        check("cmp_imm", out_imm, 8'h02);
        drain();

        // PUSH r0,r5,r7,LR expands into four ops
        send(16'hB5A1);
        drain();

        // POP with empty list: a single op
        send(16'hBC00);
        drain();

        // POP r0,r1,PC with a 3-cycle stall on the second op
        send(16'hBD03);
        step(1'b0, 16'h0000, 1'b1, 1'b0, acc);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b0, 1'b0, acc);
        check("stall_imm", out_imm, 8'd1);
        drain();

        // flush after two ops of PUSH r0-r7
        send(16'hB4FF);
        step(1'b0, 16'h0000, 1'b1, 1'b0, acc);
        step(1'b0, 16'h0000, 1'b1, 1'b0, acc);
        step(1'b0, 16'h0000, 1'b0, 1'b1, acc);
        step(1'b0, 16'h0000, 1'b1, 1'b0, acc);
        send(16'h1C48);
        step(1'b0, 16'h0000, 1'b1, 1'b0, acc);
        drain();

        // Asynchronous reset in the middle of an expansion
        send(16'hB4FF);
        step(1'b0, 16'h0000, 1'b1, 1'b0, acc);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_last", out_last, 0);
        check("rst_mid_opcode", out_opcode, 5'h00);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 16'h0000, 1'b1, 1'b0, acc);

        // Randomized traffic with back-pressure and occasional flush
        holding = 1'b0;
        cur     = 16'h0000;
        for (int c = 0; c < 4000; c++) begin
            if (!holding && $urandom_range(0, 3) != 0) begin
                cur     = rand_instr();
                holding = 1'b1;
            end
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 60) == 0);
            step(holding, cur, ordy, fl, acc);
            if (acc) holding = 1'b0;
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
